// File: rtl/sparse_pp_accumulator.sv
// Sums sparse Booth partial products into a signed product. One beat per cycle; result valid the cycle after the last beat.
// Beats stall on pp_valid=0. The result is held in DONE until res_ready; start is accepted only in IDLE.
module sparse_pp_accumulator #(
    parameter int B_W   = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             start_ready,
    input  logic [B_W-1:0]   operand_b,
    input  logic [2:0]       cal_cycle,
    input  logic             pp_valid,
    input  logic [1:0]       pp_index,
    input  logic [1:0]       pp_pos,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] result
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                  state, state_next;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        acc_sum;
    logic [2:0]              cnt;
    logic [2:0]              cal_clamped;
    logic [B_W-1:0]          b_reg;
    logic signed [B_W+1:0]   b_ext;
    logic signed [B_W+1:0]   pp;
    logic [ACC_W-1:0]        pp_ext;
    logic [ACC_W-1:0]        pp_shift;

    // Two guard bits let -2B of the most negative B stay exact.
    always_comb begin
        b_ext = {{2{b_reg[B_W-1]}}, b_reg};
        pp    = '0;
        case (pp_index)
            2'b00: pp = -(b_ext <<< 1);
            2'b01: pp = b_ext;
            2'b10: pp = b_ext <<< 1;
            2'b11: pp = -b_ext;
            default: pp = '0;
        endcase
        pp_ext      = {{(ACC_W-B_W-2){pp[B_W+1]}}, pp};
        pp_shift    = pp_ext << {pp_pos, 1'b0};
        acc_sum     = acc + pp_shift;
        cal_clamped = (cal_cycle > 3'd4) ? 3'd4 : cal_cycle;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (cal_clamped == 3'd0) ? DONE : ACCUM;
            ACCUM:   if (pp_valid && cnt == 3'd1) state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            cnt    <= '0;
            b_reg  <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        b_reg <= operand_b;
                        cnt   <= cal_clamped;
                        acc   <= '0;
                        if (cal_clamped == 3'd0) result <= '0;
                    end
                end
                ACCUM: begin
                    if (pp_valid) begin
                        acc <= acc_sum;
                        cnt <= cnt - 3'd1;
                        if (cnt == 3'd1) result <= acc_sum;
                    end
                end
                DONE: begin
                    if (res_ready) acc <= '0;
                end
                default: ;
            endcase
        end
    end

    assign start_ready = (state == IDLE);
    assign busy        = (state == ACCUM) || (state == DONE);
    assign res_valid   = (state == DONE);

endmodule

// File: tb/tb_sparse_pp_accumulator.sv
// Directed bench for sparse_pp_accumulator with hand-computed products.
module tb_sparse_pp_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        start_ready;
    logic [7:0]  operand_b;
    logic [2:0]  cal_cycle;
    logic        pp_valid;
    logic [1:0]  pp_index;
    logic [1:0]  pp_pos;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] result;

    int errors = 0;
    int checks = 0;

    sparse_pp_accumulator #(.B_W(8), .ACC_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_ready (start_ready),
        .operand_b   (operand_b),
        .cal_cycle   (cal_cycle),
        .pp_valid    (pp_valid),
        .pp_index    (pp_index),
        .pp_pos      (pp_pos),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] b, input logic [2:0] cc);
        start     = 1'b1;
        operand_b = b;
        cal_cycle = cc;
        step();
        start     = 1'b0;
        operand_b = 8'hA5;
        cal_cycle = 3'd3;
    endtask

    task automatic beat(input logic [1:0] idx, input logic [1:0] pos);
        pp_valid = 1'b1;
        pp_index = idx;
        pp_pos   = pos;
        step();
        pp_valid = 1'b0;
        pp_index = 2'b01;
        pp_pos   = 2'd3;
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready got=%b exp=1", start_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result got=%h exp=0000", result); end
    endtask

    task automatic test_basic();
        do_start(8'd5, 3'd2);
        checks++; if (busy !== 1'b1 || start_ready !== 1'b0) begin errors++; $display("FAIL basic_busy got=%b/%b exp=1/0", busy, start_ready); end
        beat(2'b01, 2'd0);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", res_valid); end
        beat(2'b10, 2'd1);
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL basic_latency got=%b exp=1", res_valid); end
        checks++; if (result !== 16'h002D) begin errors++; $display("FAIL basic_result got=%h exp=002d", result); end
        handshake();
        checks++; if (start_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL basic_release got=%b/%b exp=1/0", start_ready, res_valid); end
    endtask

    task automatic test_four_digit(input logic [2:0] cc, input string tag);
        do_start(8'd3, cc);
        beat(2'b11, 2'd0);
        beat(2'b01, 2'd1);
        beat(2'b10, 2'd2);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL %s_early_valid got=%b exp=0", tag, res_valid); end
        beat(2'b00, 2'd3);
        checks++; if (res_valid !== 1'b1 || result !== 16'hFEE9) begin errors++; $display("FAIL %s_result got=%b/%h exp=1/fee9", tag, res_valid, result); end
        handshake();
    endtask

    task automatic test_min_b();
        do_start(8'h80, 3'd1);
        beat(2'b00, 2'd3);
        checks++; if (res_valid !== 1'b1 || result !== 16'h4000) begin errors++; $display("FAIL minb_m2b got=%b/%h exp=1/4000", res_valid, result); end
        handshake();
        do_start(8'h80, 3'd1);
        beat(2'b11, 2'd0);
        checks++; if (res_valid !== 1'b1 || result !== 16'h0080) begin errors++; $display("FAIL minb_mb got=%b/%h exp=1/0080", res_valid, result); end
        handshake();
    endtask

    task automatic test_zero_count();
        pp_valid = 1'b1;
        pp_index = 2'b10;
        pp_pos   = 2'd2;
        do_start(8'd77, 3'd0);
        checks++; if (res_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL zero_latency got=%b/%b exp=1/1", res_valid, busy); end
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL zero_result got=%h exp=0000", result); end
        step();
        checks++; if (result !== 16'h0000 || res_valid !== 1'b1) begin errors++; $display("FAIL zero_beats_ignored got=%b/%h exp=1/0000", res_valid, result); end
        pp_valid = 1'b0;
        handshake();
    endtask

    task automatic test_stalls();
        do_start(8'd5, 3'd2);
        beat(2'b01, 2'd0);
        pp_index = 2'b00;
        step();
        step();
        checks++; if (res_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL stall_state got=%b/%b exp=0/1", res_valid, busy); end
        beat(2'b10, 2'd1);
        checks++; if (res_valid !== 1'b1 || result !== 16'h002D) begin errors++; $display("FAIL stall_result got=%b/%h exp=1/002d", res_valid, result); end
        for (int i = 0; i < 3; i++) begin
            start     = (i == 1);
            operand_b = 8'd99;
            cal_cycle = 3'd1;
            pp_valid  = 1'b1;
            step();
            checks++; if (result !== 16'h002D || start_ready !== 1'b0 || res_valid !== 1'b1) begin
                errors++; $display("FAIL hold_%0d got=%h/%b/%b exp=002d/0/1", i, result, start_ready, res_valid);
            end
        end
        start    = 1'b0;
        pp_valid = 1'b0;
        handshake();
        checks++; if (start_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL hold_release got=%b/%b exp=1/0", start_ready, busy); end
    endtask

    task automatic test_reset_abort();
        do_start(8'd3, 3'd4);
        beat(2'b11, 2'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (start_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || result !== 16'h0000) begin
            errors++; $display("FAIL abort_reset got=%b/%b/%b/%h exp=1/0/0/0000", start_ready, busy, res_valid, result);
        end
        do_start(8'd2, 3'd1);
        beat(2'b10, 2'd0);
        checks++; if (res_valid !== 1'b1 || result !== 16'h0004) begin errors++; $display("FAIL abort_new_op got=%b/%h exp=1/0004", res_valid, result); end
        handshake();
    endtask

    task automatic test_back_to_back();
        do_start(8'd7, 3'd1);
        beat(2'b01, 2'd1);
        checks++; if (result !== 16'h001C) begin errors++; $display("FAIL b2b_first got=%h exp=001c", result); end
        handshake();
        do_start(8'hFF, 3'd1);
        beat(2'b10, 2'd2);
        checks++; if (res_valid !== 1'b1 || result !== 16'hFFE0) begin errors++; $display("FAIL b2b_second got=%b/%h exp=1/ffe0", res_valid, result); end
        handshake();
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        operand_b = '0;
        cal_cycle = '0;
        pp_valid  = 1'b0;
        pp_index  = '0;
        pp_pos    = '0;
        res_ready = 1'b0;
        test_reset();
        test_basic();
        test_four_digit(3'd4, "four");
        test_four_digit(3'd7, "clamp");
        test_min_b();
        test_zero_count();
        test_stalls();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
